// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_pkg : shared exception codes, stall encodings and FSM states
// Rev 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam logic [31:0] c_exc_none = 32'h0000_0000;
  localparam logic [31:0] c_exc_eret = 32'h0000_000e;

  // One bit per held stage: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
  localparam logic [5:0] c_stall_none = 6'b000000;
  localparam logic [5:0] c_stall_id   = 6'b000111;
  localparam logic [5:0] c_stall_ex   = 6'b001111;
  localparam logic [5:0] c_stall_mem  = 6'b011111;

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_stall = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;

  typedef struct packed {
    logic id;
    logic ex;
    logic mem;
  } stallreq_t;

  // The deepest requesting stage wins since it must also hold everything upstream.
  function automatic logic [5:0] stall_encode(input stallreq_t req);
    if (req.mem)     return c_stall_mem;
    else if (req.ex) return c_stall_ex;
    else if (req.id) return c_stall_id;
    else             return c_stall_none;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_stall_monitor.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_stall_monitor : saturating stall counter plus sticky watchdog
// Rev 1.0 - initial release
// ============================================================================
module pipe_ctrl_stall_monitor #(
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_active_i,
  input  logic        clr_i,
  output logic [31:0] stall_cnt_o,
  output logic        stall_timeout_o
);

  localparam int unsigned RW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] c_limit = RW'(STALL_LIMIT);

  logic [31:0]   cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  logic          to_q, to_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_active_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;

    run_d = run_q;
    if (clr_i || !stall_active_i) run_d = '0;
    else if (run_q != c_limit)    run_d = run_q + RW'(1);

    to_d = to_q | (run_d == c_limit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      to_q  <= to_d;
    end
  end

  assign stall_cnt_o     = cnt_q;
  assign stall_timeout_o = to_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : stall merging and exception flush sequencing for the 5-stage core
// Rev 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_LIMIT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic        stall_timeout
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] c_flush_load = FCW'(FLUSH_CYCLES - 1);

  logic [1:0]     state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [31:0]    new_pc_q, new_pc_d;

  stallreq_t   w_req;
  logic        w_in_flush;
  logic        w_exc_take;
  logic [31:0] w_target;

  assign w_req      = '{id: stallreq_id_i, ex: stallreq_ex_i, mem: stallreq_mem_i};
  assign w_in_flush = (state_q == c_st_flush);
  assign w_exc_take = !w_in_flush && (excepttype_i != c_exc_none);
  assign w_target   = (excepttype_i == c_exc_eret) ? cp0_epc_i : EXC_VECTOR;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    new_pc_d = new_pc_q;
    if (w_in_flush) begin
      if (fcnt_q <= FCW'(1)) begin
        state_d  = c_st_run;
        fcnt_d   = '0;
        new_pc_d = '0;
      end else begin
        fcnt_d = fcnt_q - FCW'(1);
      end
    end else if (w_exc_take) begin
      // The detection cycle already counts as the first flush cycle.
      new_pc_d = w_target;
      if (FLUSH_CYCLES > 1) begin
        state_d = c_st_flush;
        fcnt_d  = c_flush_load;
      end else begin
        state_d = c_st_run;
      end
    end else if (|w_req) begin
      state_d = c_st_stall;
    end else begin
      state_d = c_st_run;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= c_st_run;
      fcnt_q   <= '0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign flush  = w_exc_take | w_in_flush;
  assign stall  = flush ? c_stall_none : stall_encode(w_req);
  assign new_pc = w_in_flush ? new_pc_q : (w_exc_take ? w_target : 32'h0);

  pipe_ctrl_stall_monitor #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_monitor (
    .clk             (clk),
    .rst             (rst),
    .stall_active_i  (|stall),
    .clr_i           (flush),
    .stall_cnt_o     (stall_cnt),
    .stall_timeout_o (stall_timeout)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_ctrl : directed vector table plus hand sequences for pipe_ctrl
// Rev 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  typedef struct {
    logic        id;
    logic        ex;
    logic        mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        to;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        id, ex, mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;
  logic        stall_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs [20];

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .FLUSH_CYCLES (2),
    .STALL_LIMIT  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (id),
    .stallreq_ex_i  (ex),
    .stallreq_mem_i (mem),
    .excepttype_i   (exc),
    .cp0_epc_i      (epc),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall_cnt      (stall_cnt),
    .stall_timeout  (stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] st, input logic fl,
                         input logic [31:0] pc, input logic [31:0] cnt, input logic to);
    chk({tag, " stall"},   {26'd0, stall},         {26'd0, st});
    chk({tag, " flush"},   {31'd0, flush},         {31'd0, fl});
    chk({tag, " new_pc"},  new_pc,                 pc);
    chk({tag, " cnt"},     stall_cnt,              cnt);
    chk({tag, " timeout"}, {31'd0, stall_timeout}, {31'd0, to});
  endtask

  // Inputs change at negedge; outputs are sampled 2 time units later, well before the posedge.
  task automatic drive(input logic i_id, input logic i_ex, input logic i_mem,
                       input logic [31:0] i_exc, input logic [31:0] i_epc);
    @(negedge clk);
    id = i_id; ex = i_ex; mem = i_mem; exc = i_exc; epc = i_epc;
    #2;
  endtask

  function automatic vec_t mk(input logic i_id, input logic i_ex, input logic i_mem,
                              input logic [31:0] i_exc, input logic [31:0] i_epc,
                              input logic [5:0] e_st, input logic e_fl,
                              input logic [31:0] e_pc, input logic [31:0] e_cnt, input logic e_to);
    vec_t v;
    v.id = i_id; v.ex = i_ex; v.mem = i_mem; v.exc = i_exc; v.epc = i_epc;
    v.st = e_st; v.fl = e_fl; v.pc = e_pc; v.cnt = e_cnt; v.to = e_to;
    return v;
  endfunction

  initial begin
    // Expected stall_cnt is the count before this cycle's edge.
    vecs[0]  = mk(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    32'd0,  0);
    vecs[1]  = mk(1, 0, 0, 32'h0, 32'h0,    6'b000111, 0, 32'h0,    32'd0,  0);
    vecs[2]  = mk(1, 0, 0, 32'h0, 32'h0,    6'b000111, 0, 32'h0,    32'd1,  0);
    vecs[3]  = mk(1, 0, 0, 32'h0, 32'h0,    6'b000111, 0, 32'h0,    32'd2,  0);
    vecs[4]  = mk(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    32'd3,  0);
    vecs[5]  = mk(1, 1, 1, 32'h0, 32'h0,    6'b011111, 0, 32'h0,    32'd3,  0);
    vecs[6]  = mk(1, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0,    32'd4,  0);
    vecs[7]  = mk(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    32'd5,  0);
    vecs[8]  = mk(0, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0,    32'd5,  0);
    vecs[9]  = mk(0, 0, 1, 32'h0, 32'h0,    6'b011111, 0, 32'h0,    32'd6,  0);
    vecs[10] = mk(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    32'd7,  0);
    vecs[11] = mk(0, 0, 0, 32'h8, 32'h0,    6'b000000, 1, 32'h20,   32'd7,  0);
    vecs[12] = mk(1, 0, 0, 32'h0, 32'h0,    6'b000000, 1, 32'h20,   32'd7,  0);
    vecs[13] = mk(1, 0, 0, 32'h0, 32'h0,    6'b000111, 0, 32'h0,    32'd7,  0);
    vecs[14] = mk(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    32'd8,  0);
    vecs[15] = mk(0, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0,    32'd8,  0);
    vecs[16] = mk(0, 1, 0, 32'he, 32'h1234, 6'b000000, 1, 32'h1234, 32'd9,  0);
    vecs[17] = mk(0, 1, 0, 32'h8, 32'h5678, 6'b000000, 1, 32'h1234, 32'd9,  0);
    vecs[18] = mk(0, 1, 0, 32'h0, 32'h5678, 6'b001111, 0, 32'h0,    32'd9,  0);
    vecs[19] = mk(0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    32'd10, 0);

    rst = 1'b0; id = 0; ex = 0; mem = 0; exc = '0; epc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk_all("reset", 6'b000000, 0, 32'h0, 32'd0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].exc, vecs[i].epc);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].pc, vecs[i].cnt, vecs[i].to);
    end

    // Watchdog: limit 8, mem request held for 10 cycles.
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 32'h0, 32'h0);
      chk($sformatf("wd%0d stall", i), {26'd0, stall}, {26'd0, 6'b011111});
      chk($sformatf("wd%0d timeout", i), {31'd0, stall_timeout}, {31'd0, (i >= 9)});
    end
    drive(0, 0, 0, 32'h0, 32'h0);
    chk_all("wd_drop", 6'b000000, 0, 32'h0, 32'd20, 1);
    drive(0, 0, 0, 32'h8, 32'h0);
    chk_all("wd_flush0", 6'b000000, 1, 32'h20, 32'd20, 1);
    drive(0, 0, 0, 32'h0, 32'h0);
    chk_all("wd_flush1", 6'b000000, 1, 32'h20, 32'd20, 1);
    drive(0, 0, 0, 32'h0, 32'h0);
    chk_all("wd_after", 6'b000000, 0, 32'h0, 32'd20, 1);

    // Async reset in the middle of a flush window.
    drive(0, 0, 0, 32'h8, 32'h0);
    chk({"ar_enter", " flush"}, {31'd0, flush}, 32'd1);
    @(posedge clk);
    #1;
    exc = '0;
    #1;
    chk("ar_mid flush", {31'd0, flush}, 32'd1);
    chk("ar_mid new_pc", new_pc, 32'h20);
    #1;
    rst = 1'b0;
    #1;
    chk_all("ar_async", 6'b000000, 0, 32'h0, 32'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 0, 32'h0, 32'h0);
    chk_all("ar_run", 6'b000111, 0, 32'h0, 32'd0, 0);
    drive(0, 0, 0, 32'h0, 32'h0);
    chk_all("ar_idle", 6'b000000, 0, 32'h0, 32'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
